// File: rtl/vertex_mvp_transform.sv
// Clip-space vertex transform: (x', y', z', w') = M * (x, y, z, 1) using one shared
// multiply-accumulate, 12 MAC cycles per vertex, valid/ready on both sides.
module vertex_mvp_transform #(
  parameter int unsigned WMI = 8,
  parameter int unsigned WMF = 8,
  parameter int unsigned WVI = 8,
  parameter int unsigned WVF = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0][WMI+WMF-1:0]      matrix,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WVI+WVF-1:0]            in_x,
  input  logic [WVI+WVF-1:0]            in_y,
  input  logic [WVI+WVF-1:0]            in_z,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WMI+WMF-1:0]            out_x,
  output logic [WMI+WMF-1:0]            out_y,
  output logic [WMI+WMF-1:0]            out_z,
  output logic [WMI+WMF-1:0]            out_w,
  output logic                          overflow
);

  localparam int unsigned WM = WMI + WMF;
  localparam int unsigned WV = WVI + WVF;
  localparam int unsigned WP = WM + WV;
  localparam int unsigned WA = WP + 2;
  localparam int unsigned WR = WA - WVF;

  localparam logic signed [WA-1:0] RND    = WA'(1) <<< (WVF - 1);
  localparam logic signed [WR-1:0] SAT_HI = {{(WR-WM+1){1'b0}}, {(WM-1){1'b1}}};
  localparam logic signed [WR-1:0] SAT_LO = {{(WR-WM+1){1'b1}}, {(WM-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state_q, state_d;

  logic [15:0][WM-1:0]   m_q;
  logic signed [WV-1:0]  x_q, y_q, z_q;
  logic [1:0]            row, col;
  logic signed [WA-1:0]  acc;

  logic accept, mac_en, last_mac;

  logic signed [WM-1:0]  coef, bias_el;
  logic signed [WV-1:0]  vert;
  logic signed [WP-1:0]  prod;
  logic signed [WA-1:0]  base, acc_sum, acc_rnd, acc_shr;
  logic signed [WR-1:0]  rounded;
  logic [WM-1:0]         result;
  logic                  sat;

  assign last_mac = (row == 2'd3) && (col == 2'd2);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = MAC;
      MAC:     if (last_mac) state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded handshake and control
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mac_en    = 1'b0;
    unique case (state_q)
      IDLE:    in_ready  = 1'b1;
      MAC:     mac_en    = 1'b1;
      OUT:     out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
    accept = in_valid & in_ready;
  end

  // Shared MAC; column 0 starts from the translation term to realise w = 1
  always_comb begin
    coef    = m_q[{row, col}];
    bias_el = m_q[{row, 2'd3}];
    unique case (col)
      2'd0:    vert = x_q;
      2'd1:    vert = y_q;
      default: vert = z_q;
    endcase
    prod    = WP'(coef) * WP'(vert);
    base    = (col == 2'd0) ? (WA'(bias_el) <<< WVF) : acc;
    acc_sum = base + WA'(prod);
    acc_rnd = acc_sum + RND;
    acc_shr = acc_rnd >>> WVF;
    rounded = WR'(acc_shr);
    sat     = 1'b0;
    result  = rounded[WM-1:0];
    if (rounded > SAT_HI) begin
      result = SAT_HI[WM-1:0];
      sat    = 1'b1;
    end else if (rounded < SAT_LO) begin
      result = SAT_LO[WM-1:0];
      sat    = 1'b1;
    end
  end

  // Operand capture, row/column sequencing and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      row      <= '0;
      col      <= '0;
      acc      <= '0;
      out_x    <= '0;
      out_y    <= '0;
      out_z    <= '0;
      out_w    <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      m_q      <= matrix;
      x_q      <= in_x;
      y_q      <= in_y;
      z_q      <= in_z;
      row      <= '0;
      col      <= '0;
      overflow <= 1'b0;
    end else if (mac_en) begin
      acc <= acc_sum;
      if (col == 2'd2) begin
        col      <= '0;
        row      <= row + 2'd1;
        overflow <= overflow | sat;
        unique case (row)
          2'd0:    out_x <= result;
          2'd1:    out_y <= result;
          2'd2:    out_z <= result;
          default: out_w <= result;
        endcase
      end else begin
        col <= col + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_vertex_mvp_transform.sv
// Scoreboard bench for vertex_mvp_transform: directed cases plus random vertices
// checked against a plain-arithmetic matrix-vector reference.
module tb_vertex_mvp_transform;

  logic               clk = 1'b0;
  logic               rst;
  logic [15:0][15:0]  matrix;
  logic               in_valid, in_ready;
  logic [15:0]        in_x, in_y, in_z;
  logic               out_valid, out_ready;
  logic [15:0]        out_x, out_y, out_z, out_w;
  logic               overflow;

  typedef struct {
    logic [3:0][15:0] o;
    logic             ovf;
    int               acc_cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rdy_mode = 0;
  bit   seen     = 0;

  vertex_mvp_transform dut (
    .clk(clk), .rst(rst), .matrix(matrix),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_w(out_w),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: clip = M * (x, y, z, 1) in real-valued fixed point, rounded half up, clamped
  function automatic exp_t model(input logic [15:0][15:0] m, input logic [15:0] x,
                                 input logic [15:0] y, input logic [15:0] z);
    exp_t   e;
    longint v[4];
    longint s, d;
    v[0] = longint'($signed(x));
    v[1] = longint'($signed(y));
    v[2] = longint'($signed(z));
    v[3] = 256;
    e.ovf = 1'b0;
    e.acc_cyc = 0;
    for (int r = 0; r < 4; r++) begin
      s = 0;
      for (int c = 0; c < 4; c++) s += longint'($signed(m[4*r+c])) * v[c];
      s = s + 128;
      d = s / 256;
      if ((s % 256) != 0 && s < 0) d = d - 1;
      if (d > 32767)  begin d = 32767;  e.ovf = 1'b1; end
      if (d < -32768) begin d = -32768; e.ovf = 1'b1; end
      e.o[r] = 16'(d);
    end
    return e;
  endfunction

  function automatic logic [15:0][15:0] ident();
    logic [15:0][15:0] r = '0;
    r[0] = 16'h0100; r[5] = 16'h0100; r[10] = 16'h0100; r[15] = 16'h0100;
    return r;
  endfunction

  function automatic exp_t mk(input logic [15:0] ox, input logic [15:0] oy,
                              input logic [15:0] oz, input logic [15:0] ow, input logic ov);
    exp_t e;
    e.o[0] = ox; e.o[1] = oy; e.o[2] = oz; e.o[3] = ow;
    e.ovf = ov; e.acc_cyc = 0;
    return e;
  endfunction

  function automatic logic [15:0] rval(input bit wide);
    logic [15:0] v;
    if (wide) v = 16'($urandom);
    else      v = 16'($urandom_range(0, 2047)) - 16'd1024;
    return v;
  endfunction

  // Offer one vertex; queue the expected result at the handshake, then scramble inputs
  task automatic send(input logic [15:0][15:0] m, input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] z, input bit use_e, input exp_t ee);
    int   t = 0;
    exp_t e;
    @(negedge clk);
    matrix = m; in_x = x; in_y = y; in_z = z; in_valid = 1'b1;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout in_ready stuck low for %0d cycles", t);
      in_valid = 1'b0;
      return;
    end
    e = use_e ? ee : model(m, x, y, z);
    e.acc_cyc = cyc;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) matrix[i] = 16'($urandom);
    in_x = 16'($urandom); in_y = 16'($urandom); in_z = 16'($urandom);
  endtask

  task automatic drain(input int limit);
    int t = 0;
    while (q.size() != 0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout %0d results still pending", q.size());
      q.delete();
    end
  endtask

  // Downstream ready: 0 = always, 1 = random, 2 = held low
  always @(negedge clk) begin
    if (rdy_mode == 0)      out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else                    out_ready = 1'b0;
  end

  // Monitor: compare every presented result against the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      seen = 0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_out out_x=%0h with empty scoreboard", out_x);
      end else begin
        e = q[0];
        if (!seen) begin
          chk("latency", cyc, e.acc_cyc + 13);
          seen = 1;
        end
        chk("out_x", out_x, e.o[0]);
        chk("out_y", out_y, e.o[1]);
        chk("out_z", out_z, e.o[2]);
        chk("out_w", out_w, e.o[3]);
        chk("overflow", overflow, e.ovf);
        chk("in_ready_busy", in_ready, 0);
        if (out_ready) begin
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end

  initial begin
    logic [15:0][15:0] m;
    exp_t none;
    int t;
    none = mk(16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    rst = 1'b1; in_valid = 1'b0; matrix = '0; in_x = '0; in_y = '0; in_z = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_w", out_w, 0);
    chk("rst_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b0;

    // Identity
    send(ident(), 16'h0100, 16'hFE00, 16'h0380, 1,
         mk(16'h0100, 16'hFE00, 16'h0380, 16'h0100, 1'b0));
    drain(100);

    // Projection-shaped
    m = '0;
    m[0] = 16'h0200; m[5] = 16'h0100; m[10] = 16'hFF00; m[11] = 16'h0080; m[14] = 16'h0100;
    send(m, 16'h0100, 16'h0100, 16'hFE00, 1,
         mk(16'h0200, 16'h0100, 16'h0280, 16'hFE00, 1'b0));

    // Rounding on the x row
    m = ident(); m[0] = 16'h0001;
    send(m, 16'h0080, 16'h0000, 16'h0000, 1, mk(16'h0001, 16'h0, 16'h0, 16'h0100, 1'b0));
    send(m, 16'hFF80, 16'h0000, 16'h0000, 1, mk(16'h0000, 16'h0, 16'h0, 16'h0100, 1'b0));
    send(m, 16'h0180, 16'h0000, 16'h0000, 1, mk(16'h0002, 16'h0, 16'h0, 16'h0100, 1'b0));

    // Saturation, then overflow clears on the next vertex
    m = ident(); m[0] = 16'h7FFF;
    send(m, 16'h7FFF, 16'h0000, 16'h0000, 1, mk(16'h7FFF, 16'h0, 16'h0, 16'h0100, 1'b1));
    send(ident(), 16'h0200, 16'h0300, 16'hFF00, 1,
         mk(16'h0200, 16'h0300, 16'hFF00, 16'h0100, 1'b0));
    drain(100);

    // Backpressure with busy-time input changes
    rdy_mode = 2;
    send(ident(), 16'h0123, 16'h0456, 16'hF789, 0, none);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("bp_out_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      for (int k = 0; k < 16; k++) matrix[k] = 16'($urandom);
      in_x = 16'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rdy_mode = 0;
    drain(20);
    #2;
    chk("bp_in_ready_after", in_ready, 1);
    chk("bp_out_valid_after", out_valid, 0);

    // Reset mid-MAC discards the vertex in flight
    send(ident(), 16'h0500, 16'h0600, 16'h0700, 0, none);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_x", out_x, 0);
    chk("mrst_out_y", out_y, 0);
    chk("mrst_out_z", out_z, 0);
    chk("mrst_out_w", out_w, 0);
    chk("mrst_overflow", overflow, 0);
    send(ident(), 16'h0100, 16'hFE00, 16'h0380, 1,
         mk(16'h0100, 16'hFE00, 16'h0380, 16'h0100, 1'b0));
    drain(100);

    // Random vertices, random matrices, random downstream stalls
    rdy_mode = 1;
    for (int n = 0; n < 40; n++) begin
      bit wide;
      wide = (n % 3) == 0;
      for (int k = 0; k < 16; k++) m[k] = rval(wide);
      send(m, rval(wide), rval(wide), rval(n % 4 == 1), 0, none);
    end
    drain(1000);
    rdy_mode = 0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vertex_mvp_transform.md
Name: vertex_mvp_transform

Overview:
- Sequential consumer of the 4x4 projection (or full MVP) matrix produced by the matrix-generation stage.
- Accepts one object-space vertex (x, y, z; w implied 1) per valid/ready handshake.
- Computes clip-space (x', y', z', w') = M·(x, y, z, 1) with a single shared multiplier/accumulator.
- Hands the result to the downstream perspective-divide / rasteriser stage over a valid/ready handshake.

Parameters:
WMI, 8, integer bits of each matrix element (signed fixed point)
WMF, 8, fractional bits of each matrix element
WVI, 8, integer bits of vertex coordinates
WVF, 8, fractional bits of vertex coordinates
(Output coordinates use the matrix format WMI.WMF.)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
matrix  in  [15:0][WMI+WMF]  row-major matrix: element [4r+c] is row r, column c
in_valid  in  1  vertex present
in_ready  out  1  block can accept a vertex
in_x, in_y, in_z  in  WVI+WVF each  signed vertex coordinates
out_valid  out  1  clip-space result present
out_ready  in  1  downstream accepts result
out_x, out_y, out_z, out_w  out  WMI+WMF each  signed clip coordinates
overflow  out  1  one or more of the four results saturated (valid with out_valid)

Behaviour:
Interface decision:
- One clock, clk. Reset rst is synchronous and active-high.

Reset:
- State returns to IDLE.
- in_ready=1, out_valid=0, out_x/y/z/w=0, overflow=0.
- Internal row/column counters and accumulator are cleared.
- rst asserted mid-computation or while out_valid is high discards the vertex in flight. No partial output is ever presented.

States:
- IDLE: in_ready=1. On in_valid&in_ready, latch in_x/y/z and all 16 matrix elements, clear overflow, and go to MAC with row r=0, col c=0. The matrix is sampled only at acceptance; later changes do not affect the vertex in flight.
- MAC: in_ready=0. Each cycle processes one (r, c), c in 0..2.
  - c=0: acc = (m[4r+3] << WVF) + m[4r+0]*x.
  - c=1: acc += m[4r+1]*y.
  - c=2: acc += m[4r+2]*z, then round and saturate acc into output register r (0=x', 1=y', 2=z', 3=w').
  - After c=2: r increments. After r=3, c=2, go to OUT.
  - Total 12 MAC cycles.
- OUT: out_valid=1 and outputs held stable. On out_valid&out_ready, go to IDLE; out_valid drops the next cycle. Outputs keep their last values while in IDLE.

Timing:
- Handshake in cycle T gives out_valid high from T+13.
- Minimum vertex period is 14 cycles. A new vertex cannot be accepted in the same cycle as the output handshake.

Arithmetic:
- Products are full precision, signed WMI+WMF by WVI+WVF.
- Accumulator is signed, WMI+WMF+WVI+WVF+2 bits. No intermediate overflow is possible.
- Result = (acc + 2^(WVF-1)) >>> WVF, i.e. round half toward +infinity.
- The result is then saturated to the signed WMI+WMF range: max 0x7FFF, min 0x8000 for defaults.
- Any saturation sets overflow, which is sticky until the next acceptance.
- Implied w=1 is realised by the column-3 preload. There is no fourth multiply.

Boundaries:
- in_valid while busy is ignored (in_ready=0). The upstream stage holds its data.
- out_ready held low stalls indefinitely with outputs and overflow stable.
- out_ready high before out_valid has no effect.

Test Plan:
- Identity matrix (0x0100 at indices 0,5,10,15, all others 0), vertex (0x0100, 0xFE00, 0x0380) -> out (0x0100, 0xFE00, 0x0380, 0x0100), overflow=0. out_valid exactly 13 cycles after the input handshake.
- Projection-shaped matrix m0=0x0200, m5=0x0100, m10=0xFF00, m11=0x0080, m14=0x0100, all others 0; vertex (0x0100, 0x0100, 0xFE00) -> out (0x0200, 0x0100, 0x0280, 0xFE00).
- Rounding, identity matrix except m0=0x0001:
  - x=0x0080 -> out_x=0x0001.
  - x=0xFF80 -> out_x=0x0000.
  - x=0x0180 -> out_x=0x0002.
- Saturation: m0=0x7FFF, x=0x7FFF -> out_x=0x7FFF, overflow=1. Next vertex with identity matrix -> overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Outputs stay constant, in_ready=0, and a changed matrix/in_* is ignored. Release out_ready -> one transfer, then in_ready=1 the following cycle.
- Reset mid-MAC (cycle T+6): next cycle in_ready=1, out_valid=0, all outputs 0. A fresh identity-matrix vertex then completes with correct values at T'+13.
